// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle between two ALU clients, the shared-ALU arbiter and the result consumer.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int OP_W  = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin issue of two requesters into one ALU with a one-entry result pipe stage.
// Define ALU_ARB_STATS_EN to add per-requester saturating grant counters and a conflict flag.
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int OP_W  = 4
) (
  input logic clk,
  input logic reset,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [0:0]  conflict
`endif
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(4'b1000);
  logic             can_issue;
  logic             both;
  logic             gnt;
  logic             accept;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_res;
  logic             rsp_valid_d, rsp_valid_q;
  logic             rsp_id_d, rsp_id_q;
  logic             last_gnt_d, last_gnt_q;
  logic [WIDTH-1:0] rsp_result_d, rsp_result_q;
  // Readies are gated by reset so nothing is offered while the block is held.
  always_comb begin
    can_issue = ~rsp_valid_q | bus.rsp_ready;
    both      = bus.req0_valid & bus.req1_valid;
    gnt       = both ? ~last_gnt_q : bus.req1_valid;
    accept    = ~reset & can_issue & (bus.req0_valid | bus.req1_valid);
    op        = gnt ? bus.req1_op : bus.req0_op;
    a         = gnt ? bus.req1_a : bus.req0_a;
    b         = gnt ? bus.req1_b : bus.req0_b;
    alu_res   = op == OP_AND ? a & b :
                op == OP_OR  ? a | b :
                op == OP_ADD ? a + b :
                op == OP_SUB ? a - b :
                op == OP_SLL ? a << b[SH_W-1:0] : '0;
    rsp_valid_d  = accept | (rsp_valid_q & ~bus.rsp_ready);
    rsp_id_d     = accept ? gnt : rsp_id_q;
    rsp_result_d = accept ? alu_res : rsp_result_q;
    last_gnt_d   = accept ? gnt : last_gnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      last_gnt_q   <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      last_gnt_q   <= last_gnt_d;
    end
  end
  assign bus.req0_ready = accept & ~gnt;
  assign bus.req1_ready = accept & gnt;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_result_q == '0;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_d, cnt0_q;
  logic [15:0] cnt1_d, cnt1_q;
  logic        conflict_d, conflict_q;
  always_comb begin
    cnt0_d     = (accept & ~gnt & ~&cnt0_q) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d     = (accept & gnt & ~&cnt1_q) ? cnt1_q + 16'd1 : cnt1_q;
    conflict_d = ~reset & both & can_issue;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      conflict_q <= conflict_d;
    end
  end
  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
  assign conflict = conflict_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  alu_share_arbiter_if #(.WIDTH(64), .OP_W(4)) bus ();
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
  logic [0:0]  conflict;
`endif
  alu_share_arbiter #(.WIDTH(64), .OP_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0(gnt_cnt0),
    .gnt_cnt1(gnt_cnt1),
    .conflict(conflict)
`endif
  );
  always #5 clk = ~clk;

  // Model: the result register's contents plus the round-robin pointer and stats.
  logic        m_valid, m_id, m_last, m_conf;
  logic [63:0] m_res;
  logic [15:0] m_c0, m_c1;

  typedef struct { logic [3:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] res; logic z; } vec_t;
  vec_t tbl[7];
  logic [3:0] ops[8];
  logic ids[4];

  function automatic logic [63:0] alu_ref(logic [3:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1000: return a << b[5:0];
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_res = 0; m_last = 1; m_conf = 0; m_c0 = 0; m_c1 = 0;
  endtask

  task automatic drive(logic v0, logic [3:0] o0, logic [63:0] a0, logic [63:0] b0,
                       logic v1, logic [3:0] o1, logic [63:0] a1, logic [63:0] b1, logic rr);
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready = rr;
  endtask

  // One cycle: check readies before the edge, advance the model, check the result register after.
  task automatic step();
    logic free, win, v0, v1;
    #1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    free = !m_valid || bus.rsp_ready;
    win = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", bus.req0_ready, free && v0 && !win);
    chk("req1_ready", bus.req1_ready, free && v1 && win);
    @(posedge clk);
    m_conf = v0 && v1 && free;
    if (free && (v0 || v1)) begin
      m_valid = 1;
      m_id = win;
      m_res = win ? alu_ref(bus.req1_op, bus.req1_a, bus.req1_b) : alu_ref(bus.req0_op, bus.req0_a, bus.req0_b);
      m_last = win;
      if (!win && m_c0 != 16'hFFFF) m_c0++;
      if (win && m_c1 != 16'hFFFF) m_c1++;
    end else if (bus.rsp_ready) m_valid = 0;
    #1;
    chk("rsp_valid", bus.rsp_valid, m_valid);
    chk("rsp_id", bus.rsp_id, m_id);
    chk("rsp_result", bus.rsp_result, m_res);
    chk("rsp_zero", bus.rsp_zero, m_res == 0);
`ifdef ALU_ARB_STATS_EN
    chk("gnt_cnt0", gnt_cnt0, m_c0);
    chk("gnt_cnt1", gnt_cnt1, m_c1);
    chk("conflict", conflict, m_conf);
`endif
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge arrives.
  task automatic do_reset();
    #2 reset = 1;
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0};
    tbl[1] = '{4'b0110, 64'd3, 64'd3, 64'd0, 1'b1};
    tbl[2] = '{4'b1000, 64'd1, 64'd63, 64'h8000000000000000, 1'b0};
    tbl[3] = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0};
    tbl[4] = '{4'b0001, 64'hF0, 64'h3C, 64'hFC, 1'b0};
    tbl[5] = '{4'b1111, 64'hF0, 64'h3C, 64'h0, 1'b1};
    tbl[6] = '{4'b0110, 64'd0, 64'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b0011, 4'b1111, 4'b0111};
    ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    model_reset();
    drive(1, 4'b0010, 64'd1, 64'd1, 1, 4'b0010, 64'd2, 64'd2, 1);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, tbl[i].op, tbl[i].a, tbl[i].b, 0, 4'b0, 64'd0, 64'd0, 1);
      step();
      chk("tbl_result", bus.rsp_result, tbl[i].res);
      chk("tbl_zero", bus.rsp_zero, tbl[i].z);
    end
    drive(0, 4'b0, 64'd0, 64'd0, 1, 4'b0010, 64'd40, 64'd2, 0);
    for (int i = 0; i < 3; i++) begin
      bus.req1_a = 64'd40 + 64'(i);
      step();
      chk("bp_held", bus.rsp_result, 64'hFFFFFFFFFFFFFFFF);
    end
    bus.rsp_ready = 1;
    #1 chk("bp_release_ready1", bus.req1_ready, 1);
    step();
    chk("bp_release_result", bus.rsp_result, 64'd44);
    drive(1, 4'b0010, 64'd9, 64'd9, 0, 4'b0, 64'd0, 64'd0, 0);
    step();
    step();
    do_reset();
    drive(1, 4'b0010, 64'd100, 64'd1, 1, 4'b0110, 64'd100, 64'd1, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_id", bus.rsp_id, ids[i]);
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 7)], {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 9) < 7, ops[$urandom_range(0, 7)], {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 9) < 6);
      step();
    end
`ifdef ALU_ARB_STATS_EN
    do_reset();
    drive(1, 4'b0010, 64'd1, 64'd1, 0, 4'b0, 64'd0, 64'd0, 1);
    for (int i = 0; i < 3; i++) step();
    drive(0, 4'b0, 64'd0, 64'd0, 1, 4'b0001, 64'd1, 64'd2, 1);
    for (int i = 0; i < 2; i++) step();
    drive(0, 4'b0, 64'd0, 64'd0, 0, 4'b0, 64'd0, 64'd0, 1);
    step();
    chk("stats_cnt0", gnt_cnt0, 16'd3);
    chk("stats_cnt1", gnt_cnt1, 16'd2);
    drive(1, 4'b0010, 64'd1, 64'd1, 0, 4'b0, 64'd0, 64'd0, 1);
    for (int i = 0; i < 65540; i++) step();
    chk("stats_sat", gnt_cnt0, 16'hFFFF);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
